// File: rtl/spix_responder_pkg.sv
// Shared constants and state encoding for the SPI flash read responder.
// Controller benches import this to speak the same opcodes and header length.
package spix_responder_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam int CMD_BITS = 8;
    localparam int HDR_BITS = 32;
    localparam int RD_BIT   = HDR_BITS - 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_t;

    function automatic state_t decode_cmd(input logic [7:0] c);
        state_t s;
        s = ST_IGNORE;
        unique case (1'b1)
            (c == CMD_READ): s = ST_ADDR;
            (c == CMD_RDID): s = ST_ID;
            (c == CMD_RDSR): s = ST_STAT;
            default:         s = ST_IGNORE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/spix_responder.sv
// SPI flash responder: 03 read with continuous word prefetch, 9F JEDEC ID,
// 05 status. One bit per i_clk cycle in which sck is high.
module spix_responder
    import spix_responder_pkg::*;
#(
    parameter int          AW        = 22,
    parameter logic [23:0] DEVICE_ID = 24'hEF4016
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_spi_cs_n,
    input  logic          i_spi_sck,
    input  logic          i_spi_mosi,
    output logic          o_spi_miso,
    output logic          o_mem_rd,
    output logic [AW-1:0] o_mem_addr,
    input  logic [31:0]   i_mem_data
);

    localparam logic [5:0] N_CMD_END = 6'(CMD_BITS - 1);
    localparam logic [5:0] N_RD      = 6'(RD_BIT);
    localparam logic [5:0] N_HDR_END = 6'(HDR_BITS - 1);

    state_t      state, state_d;
    logic        armed;
    logic [5:0]  n;
    logic [6:0]  cmd_sh;
    logic [20:0] addr_sh;
    logic [31:0] out_sh;
    logic [31:0] nxt_word;
    logic [23:0] id_sh;
    logic        rd_d;

    logic        strobe;
    logic        hdr_phase;
    logic [7:0]  cmd;
    logic [21:0] word_addr;
    logic [31:0] load_word;

    always_comb begin
        strobe    = !i_spi_cs_n && i_spi_sck;
        hdr_phase = (state == ST_CMD) || (state == ST_IDLE && armed);
        cmd       = {cmd_sh, i_spi_mosi};
        word_addr = {addr_sh, i_spi_mosi};
        load_word = rd_d ? i_mem_data : nxt_word;
        state_d   = state;
        unique case (state)
            // unarmed means reset let go mid-frame: sit out this frame
            ST_IDLE: state_d = armed ? ST_CMD : ST_IGNORE;
            ST_CMD:
                if (strobe && n == N_CMD_END)
                    state_d = decode_cmd(cmd);
            ST_ADDR:
                if (strobe && n == N_HDR_END)
                    state_d = ST_DATA;
            default: state_d = state;
        endcase
        if (i_spi_cs_n)
            state_d = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            armed      <= 1'b0;
            n          <= '0;
            cmd_sh     <= '0;
            addr_sh    <= '0;
            out_sh     <= '0;
            nxt_word   <= '0;
            id_sh      <= '0;
            rd_d       <= 1'b0;
            o_spi_miso <= 1'b0;
            o_mem_rd   <= 1'b0;
            o_mem_addr <= '0;
        end else begin
            armed    <= armed | i_spi_cs_n;
            o_mem_rd <= 1'b0;
            rd_d     <= o_mem_rd;
            if (rd_d)
                nxt_word <= i_mem_data;
            if (i_spi_cs_n) begin
                n          <= '0;
                cmd_sh     <= '0;
                addr_sh    <= '0;
                out_sh     <= '0;
                id_sh      <= '0;
                o_spi_miso <= 1'b0;
            end else if (strobe) begin
                n <= n + 6'd1;
                unique case (state)
                    ST_IDLE, ST_CMD: begin
                        if (hdr_phase) begin
                            cmd_sh <= cmd[6:0];
                            if (state_d == ST_ID) begin
                                o_spi_miso <= DEVICE_ID[23];
                                id_sh <= {DEVICE_ID[22:0], DEVICE_ID[23]};
                            end
                        end
                    end
                    ST_ADDR: begin
                        addr_sh <= word_addr[20:0];
                        if (n == N_RD) begin
                            o_mem_rd   <= 1'b1;
                            o_mem_addr <= AW'(word_addr);
                        end
                        if (n == N_HDR_END) begin
                            o_spi_miso <= load_word[31];
                            out_sh     <= {load_word[30:0], 1'b0};
                        end
                    end
                    ST_DATA: begin
                        // prefetch the next word right after its predecessor starts
                        if (n[4:0] == 5'd0) begin
                            o_mem_rd   <= 1'b1;
                            o_mem_addr <= o_mem_addr + AW'(1);
                        end
                        if (n[4:0] == 5'd31) begin
                            o_spi_miso <= load_word[31];
                            out_sh     <= {load_word[30:0], 1'b0};
                        end else begin
                            o_spi_miso <= out_sh[31];
                            out_sh     <= {out_sh[30:0], 1'b0};
                        end
                    end
                    ST_ID: begin
                        o_spi_miso <= id_sh[23];
                        id_sh      <= {id_sh[22:0], id_sh[23]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spix_responder.sv
// Directed bench for spix_responder: frame-level model of miso and
// memory reads, checked every cycle, plus literal pins per scenario.
module tb_spix_responder;

    localparam int K_NONE = 0;
    localparam int K_READ = 1;
    localparam int K_ID   = 2;
    localparam int K_STAT = 3;
    localparam int K_IGN  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic        mem_rd;
    logic [21:0] mem_addr;
    logic [31:0] mem_data = 32'h0;

    always #5 clk = ~clk;

    spix_responder #(.AW(22), .DEVICE_ID(24'hEF4016)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_spi_cs_n (cs_n),
        .i_spi_sck  (sck),
        .i_spi_mosi (mosi),
        .o_spi_miso (miso),
        .o_mem_rd   (mem_rd),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data)
    );

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        case (a)
            22'd0:       return 32'h5A3CF069;
            22'd1:       return 32'hDEADBEEF;
            22'd2:       return 32'h01234567;
            22'd3:       return 32'h89ABCDEF;
            22'h3FFFFF:  return 32'hA5C30F96;
            default:     return {10'h0, a} ^ 32'hC0FFEE00;
        endcase
    endfunction

    // memory: data valid for the whole cycle after a read pulse, junk otherwise
    logic        rd_seen = 1'b0;
    logic [21:0] addr_seen = '0;
    always @(negedge clk) begin
        mem_data  <= rd_seen ? mem_word(addr_seen) : $urandom;
        rd_seen   <= mem_rd;
        addr_seen <= mem_addr;
    end

    int          total = 0;
    int          bad = 0;
    int          cnt = 0;
    int          kind = K_NONE;
    logic [31:0] hdr = '0;
    logic [21:0] base = '0;
    logic [21:0] last_addr = '0;
    logic        exp_miso = 1'b0;
    logic        exp_rd = 1'b0;
    logic [21:0] exp_addr = '0;
    logic [23:0] dev_id = 24'hEF4016;
    logic [63:0] cap = '0;
    logic [21:0] rd_log [64];
    int          rd_n = 0;
    int          r0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // fold the previous cycle into the model, then predict this cycle
    task automatic step_model();
        logic [31:0] w;
        exp_rd = 1'b0;
        if (!cs_n && sck) begin
            hdr = {hdr[30:0], mosi};
            if (kind == K_NONE && cnt == 7) begin
                case (hdr[7:0])
                    8'h03:   kind = K_READ;
                    8'h9F:   kind = K_ID;
                    8'h05:   kind = K_STAT;
                    default: kind = K_IGN;
                endcase
            end
            if (kind == K_READ) begin
                if (cnt == 29) begin
                    base = hdr[21:0];
                    exp_rd = 1'b1;
                    exp_addr = base;
                end else if (cnt >= 32 && (cnt - 32) % 32 == 0) begin
                    exp_rd = 1'b1;
                    exp_addr = base + 22'((cnt - 32) / 32 + 1);
                end
                if (exp_rd)
                    last_addr = exp_addr;
            end
            cnt++;
        end
        if (cs_n) begin
            cnt = 0;
            kind = K_NONE;
            hdr = '0;
        end
        exp_miso = 1'b0;
        if (kind == K_READ && cnt >= 32) begin
            w = mem_word(base + 22'((cnt - 32) / 32));
            exp_miso = w[31 - ((cnt - 32) % 32)];
        end else if (kind == K_ID && cnt >= 8) begin
            exp_miso = dev_id[23 - ((cnt - 8) % 24)];
        end
    endtask

    task automatic check_cycle();
        chk("miso", 64'(miso), 64'(exp_miso));
        chk("mem_rd", 64'(mem_rd), 64'(exp_rd));
        if (exp_rd)
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        if (!cs_n && sck)
            cap = {cap[62:0], miso};
        if (mem_rd && rd_n < 64) begin
            rd_log[rd_n] = mem_addr;
            rd_n++;
        end
    endtask

    task automatic cyc(input logic c, input logic s, input logic m);
        @(posedge clk);
        #1;
        step_model();
        cs_n = c;
        sck  = s;
        mosi = m;
        #3;
        check_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        chk("pre_rst_addr", 64'(mem_addr), 64'(last_addr));
        rst_n = 1'b0;
        kind = K_IGN;
        cnt = 0;
        exp_miso = 1'b0;
        exp_rd = 1'b0;
        last_addr = '0;
        #1;
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_rd", 64'(mem_rd), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic txn(input logic [31:0] h, input int nh, input int ns,
                       input bit gaps, input int rst_at);
        logic b;
        cap = '0;
        r0 = rd_n;
        for (int k = 0; k < ns; k++) begin
            if (k == rst_at)
                do_reset();
            b = (k < nh) ? h[nh - 1 - k] : 1'($urandom);
            cyc(1'b0, 1'b1, b);
            if (gaps)
                cyc(1'b0, 1'b0, 1'($urandom));
        end
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("init_miso", 64'(miso), 64'd0);
        chk("init_rd", 64'(mem_rd), 64'd0);
        chk("init_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);

        // single word read; low address bits ignored
        txn(32'h03000006, 32, 64, 1'b0, -1);
        chk("read_word", 64'(cap[31:0]), 64'hDEADBEEF);
        chk("read_n", 64'(rd_n - r0), 64'd2);
        chk("read_a0", 64'(rd_log[r0]), 64'd1);
        chk("read_a1", 64'(rd_log[r0 + 1]), 64'd2);

        // streaming with no gap between words
        txn(32'h03000005, 32, 96, 1'b0, -1);
        chk("stream_words", cap, 64'hDEADBEEF01234567);
        chk("stream_n", 64'(rd_n - r0), 64'd3);
        chk("stream_a1", 64'(rd_log[r0 + 1]), 64'd2);

        // top of memory, sck low every other cycle
        txn(32'h03FFFFFC, 32, 64, 1'b1, -1);
        chk("wrap_word", 64'(cap[31:0]), 64'hA5C30F96);
        chk("wrap_n", 64'(rd_n - r0), 64'd2);
        chk("wrap_a0", 64'(rd_log[r0]), 64'h3FFFFF);
        chk("wrap_a1", 64'(rd_log[r0 + 1]), 64'd0);

        // JEDEC ID twice
        txn(32'h0000009F, 8, 56, 1'b0, -1);
        chk("id_bits", 64'(cap[47:0]), 64'hEF4016EF4016);
        chk("id_no_rd", 64'(rd_n - r0), 64'd0);

        // abort mid read, then status
        txn(32'h03000004, 32, 40, 1'b0, -1);
        chk("abort_n", 64'(rd_n - r0), 64'd2);
        txn(32'h00000005, 8, 16, 1'b0, -1);
        chk("stat_bits", 64'(cap[15:0]), 64'd0);
        chk("stat_no_rd", 64'(rd_n - r0), 64'd0);

        // unknown opcode, reset mid frame
        txn(32'h000000AB, 8, 24, 1'b0, 16);
        chk("unk_bits", 64'(cap[23:0]), 64'd0);
        chk("unk_no_rd", 64'(rd_n - r0), 64'd0);

        // reset during data output
        txn(32'h03000006, 32, 40, 1'b0, 35);
        chk("rstrd_n", 64'(rd_n - r0), 64'd2);

        // reset release mid frame must not decode the following 9F
        txn(32'h9F9F9F9F, 32, 40, 1'b0, 8);
        chk("noid_bits", 64'(cap[31:0]), 64'd0);
        chk("noid_no_rd", 64'(rd_n - r0), 64'd0);

        // fresh ID frame after recovery
        txn(32'h0000009F, 8, 32, 1'b0, -1);
        chk("id2_bits", 64'(cap[23:0]), 64'hEF4016);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
